// File: rtl/adc_responder.sv
// rtl/adc_responder.sv - serial ADC-style responder: synchronised SPI-like slave returning a 12-bit sample per 16-bit frame
module adc_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RESET_CH    = 3'd0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ADC_SCLK,
  input  logic        ADC_CS_N,
  input  logic        ADC_DIN,
  output logic        ADC_DOUT,
  output logic [2:0]  CH_SEL,
  input  logic [11:0] CH_VALUE,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, WAIT_HIGH} state_t;

  localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);

  // Each stage holds {cs_n, sclk, din}; index SYNC_STAGES-1 is the synchronised value.
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [1:0]  prev_q, prev_d;
  logic [1:0]  settle_q, settle_d;
  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  rise_cnt_q, rise_cnt_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  ch_sel_q, ch_sel_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic       cs_s, sclk_s, din_s;
  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [4:0] rise_inc;

  assign {cs_s, sclk_s, din_s} = sync_q[SYNC_STAGES-1];
  assign cs_fall   = !cs_s &&  prev_q[1];
  assign cs_rise   =  cs_s && !prev_q[1];
  assign sclk_rise =  sclk_s && !prev_q[0];
  assign sclk_fall = !sclk_s &&  prev_q[0];
  assign rise_inc  = rise_cnt_q + 5'd1;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], {ADC_CS_N, ADC_SCLK, ADC_DIN}};
    prev_d       = {cs_s, sclk_s};
    settle_d     = settle_q;
    state_d      = state_q;
    shreg_d      = shreg_q;
    rise_cnt_d   = rise_cnt_q;
    addr_d       = addr_q;
    ch_sel_d     = ch_sel_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      // Synchroniser reset values are not real pin samples; wait for them to flush
      // so a frame already under way at reset release is never mistaken for a new one.
      WAIT_HIGH: begin
        if (settle_q != SETTLE) begin
          settle_d = settle_q + 2'd1;
        end else if (cs_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          shreg_d    = {4'b0000, CH_VALUE};
          rise_cnt_d = 5'd0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (!cs_fall) begin
          if (sclk_rise) begin
            rise_cnt_d = rise_inc;
            case (rise_inc)
              5'd3:    addr_d[2] = din_s;
              5'd4:    addr_d[1] = din_s;
              5'd5:    addr_d[0] = din_s;
              default: ;
            endcase
            if (rise_inc == 5'd16) begin
              ch_sel_d     = addr_q;
              frame_done_d = 1'b1;
              state_d      = DONE;
            end
          end else if (sclk_fall && rise_cnt_q >= 5'd1 && rise_cnt_q <= 5'd15) begin
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync_q       <= '1;
      prev_q       <= '1;
      settle_q     <= 2'd0;
      state_q      <= WAIT_HIGH;
      shreg_q      <= 16'd0;
      rise_cnt_q   <= 5'd0;
      addr_q       <= 3'd0;
      ch_sel_q     <= RESET_CH;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      settle_q     <= settle_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      rise_cnt_q   <= rise_cnt_d;
      addr_q       <= addr_d;
      ch_sel_q     <= ch_sel_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign ADC_DOUT   = (state_q == ACTIVE) && shreg_q[15];
  assign CH_SEL     = ch_sel_q;
  assign FRAME_DONE = frame_done_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_adc_responder.sv
// tb/tb_adc_responder.sv - directed self-checking bench for adc_responder
module tb_adc_responder;

  localparam int H = 8;

  logic        CLOCK    = 1'b0;
  logic        RESET    = 1'b1;
  logic        ADC_SCLK = 1'b1;
  logic        ADC_CS_N = 1'b1;
  logic        ADC_DIN  = 1'b0;
  logic [11:0] CH_VALUE = 12'h000;
  logic        ADC_DOUT;
  logic [2:0]  CH_SEL;
  logic        FRAME_DONE;
  logic        FRAME_ERR;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int dout_cnt = 0;

  adc_responder dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .ADC_SCLK   (ADC_SCLK),
    .ADC_CS_N   (ADC_CS_N),
    .ADC_DIN    (ADC_DIN),
    .ADC_DOUT   (ADC_DOUT),
    .CH_SEL     (CH_SEL),
    .CH_VALUE   (CH_VALUE),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    if (FRAME_DONE) done_cnt <= done_cnt + 1;
    if (FRAME_ERR)  err_cnt  <= err_cnt + 1;
    if (ADC_DOUT)   dout_cnt <= dout_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // Master side of one frame; DIN changes on the falling SCLK edge, DOUT is read just before each rise.
  task automatic run_frame(input logic [2:0] addr, input int n_rises, input logic din_fill,
                           input logic cs_low_already, input logic end_cs,
                           output logic [31:0] bits);
    bits = 32'd0;
    if (!cs_low_already) ADC_CS_N = 1'b0;
    tick(H);
    for (int i = 1; i <= n_rises; i++) begin
      ADC_SCLK = 1'b0;
      ADC_DIN  = (i == 3) ? addr[2] : (i == 4) ? addr[1] : (i == 5) ? addr[0] : din_fill;
      tick(H);
      bits     = {bits[30:0], ADC_DOUT};
      ADC_SCLK = 1'b1;
      tick(H);
    end
    if (end_cs) begin
      ADC_CS_N = 1'b1;
      ADC_DIN  = 1'b0;
      tick(H);
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_checks++; if (ADC_DOUT !== 1'b0) $display("FAIL reset_dout: got %b expected 0", ADC_DOUT); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd0) $display("FAIL reset_ch_sel: got %0d expected 0", CH_SEL); else n_pass++;
    n_checks++; if (FRAME_DONE !== 1'b0) $display("FAIL reset_done: got %b expected 0", FRAME_DONE); else n_pass++;
    n_checks++; if (FRAME_ERR !== 1'b0) $display("FAIL reset_err: got %b expected 0", FRAME_ERR); else n_pass++;
    RESET = 1'b0;
    tick(10);
  endtask

  task automatic test_basic;
    logic [31:0] bits;
    int d0, e0;
    CH_VALUE = 12'hA5C;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(3'b101, 16, 1'b0, 1'b0, 1'b1, bits);
    n_checks++; if (bits[15:0] !== 16'h0A5C) $display("FAIL basic_data: got %h expected 0a5c", bits[15:0]); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL basic_done: got %0d expected 1", done_cnt - d0); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL basic_err: got %0d expected 0", err_cnt - e0); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd5) $display("FAIL basic_ch_sel: got %0d expected 5", CH_SEL); else n_pass++;
    n_checks++; if (ADC_DOUT !== 1'b0) $display("FAIL basic_dout_idle: got %b expected 0", ADC_DOUT); else n_pass++;
  endtask

  task automatic test_pipelined;
    logic [31:0] bits;
    RESET = 1'b1; tick(2); RESET = 1'b0; tick(10);
    n_checks++; if (CH_SEL !== 3'd0) $display("FAIL pipe_ch_sel0: got %0d expected 0", CH_SEL); else n_pass++;
    CH_VALUE = 12'h777;
    run_frame(3'b010, 16, 1'b0, 1'b0, 1'b1, bits);
    n_checks++; if (bits[15:0] !== 16'h0777) $display("FAIL pipe_data1: got %h expected 0777", bits[15:0]); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd2) $display("FAIL pipe_ch_sel1: got %0d expected 2", CH_SEL); else n_pass++;
    CH_VALUE = 12'h123;
    run_frame(3'b000, 16, 1'b0, 1'b0, 1'b1, bits);
    n_checks++; if (bits[15:0] !== 16'h0123) $display("FAIL pipe_data2: got %h expected 0123", bits[15:0]); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd0) $display("FAIL pipe_ch_sel2: got %0d expected 0", CH_SEL); else n_pass++;
  endtask

  task automatic test_latency;
    int e0;
    e0 = err_cnt;
    CH_VALUE = 12'h800;
    ADC_CS_N = 1'b0;
    tick(H);
    for (int i = 0; i < 4; i++) begin
      ADC_SCLK = 1'b0; tick(H);
      ADC_SCLK = 1'b1; tick(H);
    end
    ADC_SCLK = 1'b0;
    tick(2);
    n_checks++; if (ADC_DOUT !== 1'b0) $display("FAIL latency_early: got %b expected 0", ADC_DOUT); else n_pass++;
    tick(1);
    n_checks++; if (ADC_DOUT !== 1'b1) $display("FAIL latency_on_time: got %b expected 1", ADC_DOUT); else n_pass++;
    tick(H);
    ADC_SCLK = 1'b1; tick(H);
    ADC_CS_N = 1'b1; tick(H);
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL latency_err: got %0d expected 1", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_abort;
    logic [31:0] bits;
    int d0, e0;
    CH_VALUE = 12'hABC;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(3'b111, 9, 1'b0, 1'b0, 1'b1, bits);
    n_checks++; if (bits[8:0] !== 9'h015) $display("FAIL abort_bits: got %h expected 015", bits[8:0]); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL abort_err: got %0d expected 1", err_cnt - e0); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd0) $display("FAIL abort_ch_sel: got %0d expected 0", CH_SEL); else n_pass++;
    n_checks++; if (ADC_DOUT !== 1'b0) $display("FAIL abort_dout: got %b expected 0", ADC_DOUT); else n_pass++;
    CH_VALUE = 12'h3C3;
    run_frame(3'b110, 16, 1'b0, 1'b0, 1'b1, bits);
    n_checks++; if (bits[15:0] !== 16'h03C3) $display("FAIL abort_next_data: got %h expected 03c3", bits[15:0]); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd6) $display("FAIL abort_next_ch_sel: got %0d expected 6", CH_SEL); else n_pass++;
  endtask

  task automatic test_extra_clocks;
    logic [31:0] bits;
    int d0;
    CH_VALUE = 12'hFFF;
    d0 = done_cnt;
    run_frame(3'b011, 20, 1'b1, 1'b0, 1'b1, bits);
    n_checks++; if (bits[19:4] !== 16'h0FFF) $display("FAIL extra_data: got %h expected 0fff", bits[19:4]); else n_pass++;
    n_checks++; if (bits[3:0] !== 4'h0) $display("FAIL extra_tail: got %h expected 0", bits[3:0]); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL extra_done: got %0d expected 1", done_cnt - d0); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd3) $display("FAIL extra_ch_sel: got %0d expected 3", CH_SEL); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] bits;
    int d0, e0, o0;
    CH_VALUE = 12'hFFF;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(3'b111, 6, 1'b0, 1'b0, 1'b0, bits);
    RESET = 1'b1; tick(3); RESET = 1'b0;
    o0 = dout_cnt;
    run_frame(3'b111, 10, 1'b1, 1'b1, 1'b1, bits);
    n_checks++; if (dout_cnt - o0 !== 0) $display("FAIL rmid_dout: got %0d high cycles expected 0", dout_cnt - o0); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL rmid_done: got %0d expected 0", done_cnt - d0); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL rmid_err: got %0d expected 0", err_cnt - e0); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd0) $display("FAIL rmid_ch_sel: got %0d expected 0", CH_SEL); else n_pass++;
    CH_VALUE = 12'h5A5;
    run_frame(3'b100, 16, 1'b0, 1'b0, 1'b1, bits);
    n_checks++; if (bits[15:0] !== 16'h05A5) $display("FAIL rmid_next_data: got %h expected 05a5", bits[15:0]); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd4) $display("FAIL rmid_next_ch_sel: got %0d expected 4", CH_SEL); else n_pass++;
  endtask

  task automatic test_collision;
    logic [31:0] bits;
    int d0;
    ADC_SCLK = 1'b0; tick(H);
    CH_VALUE = 12'h9E1;
    d0 = done_cnt;
    ADC_CS_N = 1'b0;
    ADC_SCLK = 1'b1;
    tick(4);
    CH_VALUE = 12'h000;
    run_frame(3'b001, 15, 1'b0, 1'b1, 1'b0, bits);
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL coll_done_early: got %0d expected 0", done_cnt - d0); else n_pass++;
    ADC_SCLK = 1'b0; ADC_DIN = 1'b0; tick(H);
    bits = {bits[30:0], ADC_DOUT};
    ADC_SCLK = 1'b1; tick(H);
    ADC_CS_N = 1'b1; tick(H);
    n_checks++; if (bits[15:0] !== 16'h09E1) $display("FAIL coll_data: got %h expected 09e1", bits[15:0]); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL coll_done: got %0d expected 1", done_cnt - d0); else n_pass++;
    n_checks++; if (CH_SEL !== 3'd1) $display("FAIL coll_ch_sel: got %0d expected 1", CH_SEL); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pipelined();
    test_latency();
    test_abort();
    test_extra_clocks();
    test_reset_mid();
    test_collision();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
